// File: rtl/uc_decode_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : uc_decode_sequencer_if
// Fetch-side, microcode-ROM and execute-side signal bundle of the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface uc_decode_sequencer_if #(
  parameter int UC_WIDTH      = 16,
  parameter int UC_ADDR_WIDTH = 6
);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_instr;
  logic                     uc_rd_en;
  logic [UC_ADDR_WIDTH-1:0] uc_addr;
  logic [UC_WIDTH-1:0]      uc_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [UC_WIDTH-2:0]      out_uop;
  logic                     out_last;
  logic                     out_illegal;
  logic [4:0]               out_rd_addr;
  logic [4:0]               out_rs1_addr;
  logic [4:0]               out_rs2_addr;
  logic [11:0]              out_i_imm;
  logic [11:0]              out_s_imm;
  logic [19:0]              out_u_imm;

  modport slave (
    input  in_valid, in_instr, uc_data, out_ready,
    output in_ready, uc_rd_en, uc_addr, out_valid, out_uop, out_last, out_illegal,
           out_rd_addr, out_rs1_addr, out_rs2_addr, out_i_imm, out_s_imm, out_u_imm
  );

  modport master (
    output in_valid, in_instr, uc_data, out_ready,
    input  in_ready, uc_rd_en, uc_addr, out_valid, out_uop, out_last, out_illegal,
           out_rd_addr, out_rs1_addr, out_rs2_addr, out_i_imm, out_s_imm, out_u_imm
  );
endinterface
`default_nettype wire

// File: rtl/uc_decode_sequencer.sv
`default_nettype none
// ============================================================================
// Module : uc_decode_sequencer
// Buffers RV32I instructions, maps each to a microcode entry and steps the
// external 1-cycle ROM until LAST. Optional macro: ILLEGAL_INSN_EN.
// Rev    : 1.0  initial release
// ============================================================================
module uc_decode_sequencer #(
  parameter int UC_WIDTH      = 16,
  parameter int UC_ADDR_WIDTH = 6,
  parameter int FIFO_DEPTH    = 2,
  parameter int MAX_UOPS      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uc_decode_sequencer_if.slave bus
);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int STEP_W = (MAX_UOPS > 1) ? $clog2(MAX_UOPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  function automatic logic [5:0] entry_addr(input logic [31:0] instr);
    logic [5:0] base;
    logic       use_f3;
    logic       use_f7;
    logic       use_env;
    base    = 6'h00;
    use_f3  = 1'b0;
    use_f7  = 1'b0;
    use_env = 1'b0;
    case (instr[6:2])
      5'b01101: base = 6'h02;
      5'b00101: base = 6'h03;
      5'b11011: base = 6'h0b;
      5'b11001: base = 6'h23;
      5'b00011: base = 6'h24;
      5'b11000: begin base = 6'h00; use_f3 = 1'b1; end
      5'b00000: begin base = 6'h08; use_f3 = 1'b1; end
      5'b01000: begin base = 6'h0e; use_f3 = 1'b1; end
      5'b00100: begin base = 6'h11; use_f3 = 1'b1; use_f7 = 1'b1; end
      5'b01100: begin base = 6'h1a; use_f3 = 1'b1; use_f7 = 1'b1; end
      5'b11100: begin base = 6'h25; use_env = 1'b1; end
      default:  base = 6'h00;
    endcase
    entry_addr = base
               + (use_f3  ? {3'b000, instr[14:12]}      : 6'h00)
               + (use_f7  ? {2'b00, instr[30], 3'b000}  : 6'h00)
               + (use_env ? {5'b00000, instr[20]}       : 6'h00);
  endfunction

`ifdef ILLEGAL_INSN_EN
  function automatic logic is_illegal(input logic [31:0] instr);
    logic known;
    case (instr[6:2])
      5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b00011, 5'b11000,
      5'b00000, 5'b01000, 5'b00100, 5'b01100, 5'b11100: known = 1'b1;
      default: known = 1'b0;
    endcase
    is_illegal = !known || (instr[1:0] != 2'b11);
  endfunction
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [31:0]              fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic [CNT_W-1:0]         count_q;
  state_t                   state_q;
  logic [UC_ADDR_WIDTH-1:0] uc_addr_q;
  logic [STEP_W-1:0]        step_q;
  logic                     out_valid_q;
  logic                     out_last_q;
  logic [UC_WIDTH-2:0]      out_uop_q;

  logic                     push_d;
  logic                     pop_d;
  logic                     launch_d;
  logic [UC_ADDR_WIDTH-1:0] launch_addr_d;
  logic [31:0]              head_d;
  logic [31:0]              next_head_d;

  assign head_d      = fifo_q[rd_ptr_q];
  // After the head pops, the next instruction is either still buffered or arriving now.
  assign next_head_d = (count_q > CNT_W'(1)) ? fifo_q[ptr_inc(rd_ptr_q)] : bus.in_instr;

  assign bus.in_ready = (count_q < CNT_W'(FIFO_DEPTH));
  assign push_d       = bus.in_valid && bus.in_ready;
  assign pop_d        = (state_q == S_EMIT) && bus.out_ready && out_last_q;

  always_comb begin
    launch_d      = 1'b0;
    launch_addr_d = uc_addr_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          launch_d      = 1'b1;
          launch_addr_d = UC_ADDR_WIDTH'(entry_addr(head_d));
        end
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          if (!out_last_q) begin
            launch_d      = 1'b1;
            launch_addr_d = uc_addr_q + UC_ADDR_WIDTH'(1);
          end else if ((count_q > CNT_W'(1)) || push_d) begin
            launch_d      = 1'b1;
            launch_addr_d = UC_ADDR_WIDTH'(entry_addr(next_head_d));
          end
        end
      end
      default: ;
    endcase
  end

  // The read strobe is presented in the cycle the read is decided so data lands in FETCH.
  assign bus.uc_rd_en = launch_d;
  assign bus.uc_addr  = launch_d ? launch_addr_d : uc_addr_q;

  always_ff @(posedge clk) begin
    if (push_d) begin
      fifo_q[wr_ptr_q] <= bus.in_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_d) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_d)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_d, pop_d})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef ILLEGAL_INSN_EN
  logic out_illegal_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      uc_addr_q   <= '0;
      step_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_uop_q   <= '0;
`ifdef ILLEGAL_INSN_EN
      out_illegal_q <= 1'b0;
`endif
    end else begin
      if (launch_d) uc_addr_q <= launch_addr_d;
      case (state_q)
        S_IDLE: begin
          if (launch_d) begin
            state_q <= S_FETCH;
            step_q  <= '0;
          end
        end
        S_FETCH: begin
          state_q     <= S_EMIT;
          out_valid_q <= 1'b1;
          out_uop_q   <= bus.uc_data[UC_WIDTH-2:0];
          // The step cap terminates runaway microcode that never sets LAST.
          out_last_q  <= bus.uc_data[UC_WIDTH-1] || (step_q == STEP_W'(MAX_UOPS - 1));
`ifdef ILLEGAL_INSN_EN
          out_illegal_q <= 1'b0;
          if (is_illegal(head_d)) begin
            out_uop_q     <= '0;
            out_last_q    <= 1'b1;
            out_illegal_q <= 1'b1;
          end
`endif
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef ILLEGAL_INSN_EN
            out_illegal_q <= 1'b0;
`endif
            if (!out_last_q) begin
              step_q  <= step_q + STEP_W'(1);
              state_q <= S_FETCH;
            end else if (launch_d) begin
              step_q  <= '0;
              state_q <= S_FETCH;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_uop   = out_uop_q;
`ifdef ILLEGAL_INSN_EN
  assign bus.out_illegal = out_illegal_q;
`else
  assign bus.out_illegal = 1'b0;
`endif

  assign bus.out_rd_addr  = head_d[11:7];
  assign bus.out_rs1_addr = head_d[19:15];
  assign bus.out_rs2_addr = head_d[24:20];
  assign bus.out_i_imm    = head_d[31:20];
  assign bus.out_s_imm    = {head_d[31:25], head_d[11:7]};
  assign bus.out_u_imm    = head_d[31:12];

endmodule
`default_nettype wire

// File: tb/tb_uc_decode_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_uc_decode_sequencer
// Directed and randomized bench for uc_decode_sequencer with a ROM model and
// an instruction-level reference model.  Rev 1.0
// ============================================================================
module tb_uc_decode_sequencer;
  localparam int MAX_UOPS = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uc_decode_sequencer_if #(.UC_WIDTH(16), .UC_ADDR_WIDTH(6)) bus ();

  uc_decode_sequencer #(
    .UC_WIDTH(16), .UC_ADDR_WIDTH(6), .FIFO_DEPTH(2), .MAX_UOPS(MAX_UOPS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [14:0] uop;
    logic        last;
    logic        ill;
    logic [5:0]  addr;
    logic [31:0] ins;
  } exp_t;

  logic [15:0] rom [64];
  exp_t        exp_q[$];
  logic [5:0]  addr_q[$];
  logic [5:0]  rd_log[$];
  logic [31:0] in_q[$];
  int          checks = 0;
  int          errors = 0;

  // ROM data is only meaningful the cycle after a read; otherwise it is noise.
  always @(posedge clk) begin
    bus.uc_data <= bus.uc_rd_en ? rom[bus.uc_addr] : 16'($urandom);
    if (rst_n && bus.uc_rd_en) rd_log.push_back(bus.uc_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_entry(input logic [31:0] ins);
    int f3  = int'(ins[14:12]);
    int f7  = ins[30] ? 8 : 0;
    int env = int'(ins[20]);
    int e;
    case (ins[6:2])
      5'b01101: e = 2;
      5'b00101: e = 3;
      5'b11011: e = 11;
      5'b11001: e = 35;
      5'b00011: e = 36;
      5'b11000: e = f3;
      5'b00000: e = 8 + f3;
      5'b01000: e = 14 + f3;
      5'b00100: e = 17 + f3 + f7;
      5'b01100: e = 26 + f3 + f7;
      5'b11100: e = 37 + env;
      default:  e = 0;
    endcase
    return e % 64;
  endfunction

  function automatic bit model_illegal(input logic [31:0] ins);
    bit known;
    case (ins[6:2])
      5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b00011, 5'b11000,
      5'b00000, 5'b01000, 5'b00100, 5'b01100, 5'b11100: known = 1'b1;
      default: known = 1'b0;
    endcase
    return !known || (ins[1:0] != 2'b11);
  endfunction

  task automatic add_expect(input logic [31:0] ins);
    int          e;
    bit          ill;
    exp_t        r;
    logic [15:0] w;
    e   = model_entry(ins);
    ill = 1'b0;
`ifdef ILLEGAL_INSN_EN
    ill = model_illegal(ins);
`endif
    for (int k = 0; k < MAX_UOPS; k++) begin
      w      = rom[(e + k) % 64];
      r.addr = 6'((e + k) % 64);
      r.ins  = ins;
      r.ill  = ill;
      r.last = w[15] || (k == MAX_UOPS - 1) || ill;
      r.uop  = ill ? 15'h0 : w[14:0];
      exp_q.push_back(r);
      addr_q.push_back(r.addr);
      if (r.last) break;
    end
  endtask

  task automatic push1(input logic [31:0] ins);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Push into an empty idle block, check read address and two-edge latency.
  task automatic single(input string tag, input logic [31:0] ins, input logic [5:0] ea,
                        input logic [14:0] euop);
    push1(ins);
    chk({tag, "_rd_en"}, bus.uc_rd_en, 1);
    chk({tag, "_addr"}, bus.uc_addr, ea);
    tick();
    chk({tag, "_fetch_gap"}, bus.out_valid, 0);
    tick();
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_uop"}, bus.out_uop, euop);
    chk({tag, "_last"}, bus.out_last, 1);
    chk({tag, "_rd"}, bus.out_rd_addr, ins[11:7]);
    chk({tag, "_iimm"}, bus.out_i_imm, ins[31:20]);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_drop"}, bus.out_valid, 0);
    chk({tag, "_ready"}, bus.in_ready, 1);
  endtask

  task automatic run_stream(input int budget, input int rdy_pct, input int vld_pct);
    int         cyc = 0;
    bit         acc_o;
    bit         acc_i;
    logic [5:0] a;
    exp_t       r;
    while ((in_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      bus.in_valid  = (in_q.size() != 0) && ($urandom_range(99) < vld_pct);
      bus.in_instr  = (in_q.size() != 0) ? in_q[0] : $urandom;
      bus.out_ready = ($urandom_range(99) < rdy_pct);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("uop_unexpected", bus.out_valid, 0);
        end else begin
          r = exp_q[0];
          chk("s_uop", bus.out_uop, r.uop);
          chk("s_last", bus.out_last, r.last);
          chk("s_illegal", bus.out_illegal, r.ill);
          chk("s_rd", bus.out_rd_addr, r.ins[11:7]);
          chk("s_rs1", bus.out_rs1_addr, r.ins[19:15]);
          chk("s_rs2", bus.out_rs2_addr, r.ins[24:20]);
          chk("s_iimm", bus.out_i_imm, r.ins[31:20]);
          chk("s_simm", bus.out_s_imm, {r.ins[31:25], r.ins[11:7]});
          chk("s_uimm", bus.out_u_imm, r.ins[31:12]);
        end
      end
      acc_o = bus.out_valid && bus.out_ready;
      acc_i = bus.in_valid && bus.in_ready;
      tick();
      cyc++;
      if (acc_o && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc_i) void'(in_q.pop_front());
      while (rd_log.size() != 0) begin
        a = rd_log.pop_front();
        if (addr_q.size() == 0) chk("rom_addr_extra", addr_q.size(), 1);
        else chk("rom_addr", a, addr_q.pop_front());
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("stream_drained", exp_q.size() + in_q.size(), 0);
    chk("stream_addrs", addr_q.size(), 0);
  endtask

  logic [6:0]  pool [11];
  logic [31:0] ins;

  initial begin
    pool = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h0F, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    for (int i = 0; i < 64; i++) rom[i] = 16'h0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h0000006F;
    bus.out_ready = 1'b0;

    // Reset with fetch pushing.
    tick(); tick(); tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_rd_en", bus.uc_rd_en, 0);
    chk("rst_uc_addr", bus.uc_addr, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_illegal", bus.out_illegal, 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", bus.uc_rd_en, 0);

    // Single-uop instructions.
    rom[6'h0b] = 16'h9234;
    rom[6'h1a] = 16'h8aaa;
    rom[6'h22] = 16'h8555;
    rom[6'h25] = 16'hc001;
    rom[6'h26] = 16'hc002;
    single("jal", 32'h0000006F, 6'h0b, 15'h1234);
    single("add", 32'h00000033, 6'h1a, 15'h0aaa);
    single("sub", 32'h40000033, 6'h22, 15'h0555);
    single("ecall", 32'h00000073, 6'h25, 15'h4001);
    single("ebreak", 32'h00100073, 6'h26, 15'h4002);

    // Three-word sequence with a stall on word 2.
    rom[2] = 16'h0101; rom[3] = 16'h0202; rom[4] = 16'h8303;
    rd_log.delete();
    push1(32'h12345037);
    tick(); tick();
    chk("w1_valid", bus.out_valid, 1);
    chk("w1_uop", bus.out_uop, 15'h0101);
    chk("w1_last", bus.out_last, 0);
    chk("w1_uimm", bus.out_u_imm, 20'h12345);
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    chk("w1_gap", bus.out_valid, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("w2_hold_valid", bus.out_valid, 1);
      chk("w2_hold_uop", bus.out_uop, 15'h0202);
      chk("w2_hold_last", bus.out_last, 0);
      chk("w2_hold_rd_en", bus.uc_rd_en, 0);
      tick();
    end
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    tick();
    chk("w3_valid", bus.out_valid, 1);
    chk("w3_uop", bus.out_uop, 15'h0303);
    chk("w3_last", bus.out_last, 1);
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    chk("w3_popped", bus.out_valid, 0);
    chk("w3_nreads", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      chk("w_addr0", rd_log[0], 2);
      chk("w_addr1", rd_log[1], 3);
      chk("w_addr2", rd_log[2], 4);
    end
    rd_log.delete();

    // FIFO full back-pressure, third accepted only after the first pop.
    add_expect(32'h00000033);
    add_expect(32'h40000033);
    add_expect(32'h0000006F);
    push1(32'h00000033);
    push1(32'h40000033);
    chk("fifo_full", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0000006F;
    tick(); tick();
    chk("fifo_still_full", bus.in_ready, 0);
    in_q.push_back(32'h0000006F);
    run_stream(200, 100, 100);

    // Microcode without LAST is capped; an illegal word is also handled.
    for (int i = 2; i < 12; i++) rom[i] = 16'($urandom) & 16'h7fff;
    rom[0] = 16'h8777;
    add_expect(32'h00000037); in_q.push_back(32'h00000037);
    add_expect(32'hFFFFFFFF); in_q.push_back(32'hFFFFFFFF);
    run_stream(400, 100, 100);

    // Randomized traffic with random ROM image and handshakes.
    for (int i = 0; i < 64; i++) begin
      rom[i] = 16'($urandom);
      rom[i][15] = ($urandom_range(2) == 0);
    end
    for (int n = 0; n < 40; n++) begin
      ins = $urandom;
      ins[6:0] = pool[$urandom_range(10)];
      if ($urandom_range(9) == 0) ins[1:0] = 2'($urandom);
      if ($urandom_range(9) == 0) ins = $urandom;
      add_expect(ins);
      in_q.push_back(ins);
    end
    run_stream(20000, 70, 70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
